ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the command path opposite to the existing PS/2 mouse receive path. It sends one command byte at a time to the mouse, e.g. 0xF4 (enable reporting) or 0xFF (reset), using the PS/2 host request-to-send sequence. It drives the shared open-drain ps2_clk/ps2_data lines through output-enable signals. It sits in the clk_100 domain beside the mouse controller; the top level owns the tristate buffers.

---
 rtl/ps2_host_tx.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// It sends one byte using the host request-to-send sequence: it inhibits the clock,
// drives the start bit, shifts the data LSB first, then parity and stop, and samples
// the device ACK. It drives the open-drain lines only through output enables.
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   tx_data/tx_valid  command byte and request; accepted when tx_valid && tx_ready
//   tx_ready, busy    idle / in-progress status
//   ps2_clk_in/ps2_data_in   raw line levels (asynchronous)
//   ps2_clk_oe/ps2_data_oe   1 = pull line low, 0 = release
//   tx_done/tx_ack_err/tx_timeout  one-cycle result pulses, exactly one per byte
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic             ready_q, busy_q;
  logic             expire;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic fe;

  // Two-flop synchronisers plus a delayed copy of the clock for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fe      = clk_prev_q & ~clk_s2_q;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      to_q      <= to_d;
      ready_q   <= (state_d == ST_IDLE);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    to_d      = 1'b0;
    expire    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          // Frame after the start bit: data LSB first, odd parity, stop
          shift_d   = {1'b1, ~^tx_data, tx_data};
          bit_cnt_d = '0;
          cnt_d     = '0;
          clk_oe_d  = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_d = cnt_inc;
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (fe) begin
          data_oe_d = ~shift_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = '0;
          if (bit_cnt_q == 4'd9) state_d = ST_ACK;
        end else begin
          cnt_d  = cnt_inc;
          expire = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
        end
      end
      ST_ACK: begin
        data_oe_d = 1'b0;
        if (fe) begin
          ack_d   = data_s2_q;
          cnt_d   = '0;
          state_d = ST_WAIT_IDLE;
        end else begin
          cnt_d  = cnt_inc;
          expire = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s2_q && data_s2_q) begin
          done_d  = ~ack_q;
          err_d   = ack_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (fe) begin
          cnt_d = '0;
        end else begin
          cnt_d  = cnt_inc;
          expire = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Device stopped clocking or the bus never went idle: abandon the frame
    if (expire) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      to_d      = 1'b1;
      cnt_d     = '0;
      state_d   = ST_IDLE;
    end
  end

  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_ack_err  = err_q;
  assign tx_timeout  = to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed testbench for ps2_host_tx with a simple PS/2 device model on open-drain lines.
module tb_ps2_host_tx;

  localparam int unsigned INHIBIT_CYCLES = 10;
  localparam int unsigned TIMEOUT_CYCLES = 200;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;

  logic dev_clk_low;
  logic dev_data_low;

  int checks;
  int errors;

  int n_clk_oe;
  int n_done;
  int n_err;
  int n_to;
  int n_multi;
  int n_bad_ready;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_ack_err (tx_ack_err),
    .tx_timeout (tx_timeout)
  );

  // Wired-AND open-drain lines with pull-ups
  assign ps2_clk_in  = !(ps2_clk_oe || dev_clk_low);
  assign ps2_data_in = !(ps2_data_oe || dev_data_low);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and line-ownership monitor
  initial begin
    n_clk_oe = 0; n_done = 0; n_err = 0; n_to = 0; n_multi = 0; n_bad_ready = 0;
  end
  always @(posedge clk) begin
    if (ps2_clk_oe === 1'b1) n_clk_oe <= n_clk_oe + 1;
    if (tx_done === 1'b1)    n_done   <= n_done + 1;
    if (tx_ack_err === 1'b1) n_err    <= n_err + 1;
    if (tx_timeout === 1'b1) n_to     <= n_to + 1;
    if ((32'(tx_done) + 32'(tx_ack_err) + 32'(tx_timeout)) > 1) n_multi <= n_multi + 1;
    if ((tx_done || tx_ack_err || tx_timeout) && (tx_ready !== 1'b1 || busy !== 1'b0))
      n_bad_ready <= n_bad_ready + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready: tx_ready=%b required 1", tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx_ready !== 1'b0) begin
      errors++; $display("FAIL accept: busy=%b tx_ready=%b required 1/0", busy, tx_ready);
    end
  endtask

  // Send a byte and clock the device side for n_edges falling edges.
  // Edge 11 is the ACK edge: the device pulls data low when ack_bit is 0.
  task automatic run_frame(input logic [7:0] b, input int n_edges, input logic ack_bit,
                           input logic hold_ack, input logic stuff_aa);
    logic [9:0] exp;
    int oe0;
    int k;
    exp = {1'b1, ~^b, b};
    oe0 = n_clk_oe;
    send_byte(b);
    k = 0;
    while (ps2_clk_oe === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (ps2_clk_oe !== 1'b0) begin
      errors++; $display("FAIL clk_release: ps2_clk_oe=%b required 0", ps2_clk_oe);
    end
    checks++;
    if (n_clk_oe - oe0 != 11) begin
      errors++; $display("FAIL inhibit_len: clk_oe cycles=%0d required 11", n_clk_oe - oe0);
    end
    checks++;
    if (ps2_data_in !== 1'b0) begin
      errors++; $display("FAIL start_bit: ps2_data=%b required 0", ps2_data_in);
    end
    if (stuff_aa) begin
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
    end
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11) dev_data_low = ~ack_bit;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      if (i <= 10) begin
        checks++;
        if (ps2_data_in !== exp[i-1]) begin
          errors++;
          $display("FAIL bit%0d byte=%h: ps2_data=%b required %b", i - 1, b, ps2_data_in, exp[i-1]);
        end
      end
      if (stuff_aa && i == 10) begin
        checks++;
        if (tx_ready !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL ignore_busy: tx_ready=%b busy=%b required 0/1", tx_ready, busy);
        end
        tx_valid = 1'b0;
      end
      dev_clk_low = 1'b0;
      if (i == 11 && !hold_ack) dev_data_low = 1'b0;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic check_result(input string name, input int d_done, input int d_err, input int d_to,
                              input int e_done, input int e_err, input int e_to);
    checks++;
    if (d_done != e_done || d_err != e_err || d_to != e_to) begin
      errors++;
      $display("FAIL %s: done/err/to=%0d/%0d/%0d required %0d/%0d/%0d",
               name, d_done, d_err, d_to, e_done, e_err, e_to);
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: ready=%b busy=%b clk_oe=%b data_oe=%b required 1/0/0/0",
               name, tx_ready, busy, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL reset_oe: clk_oe=%b data_oe=%b required 0/0", ps2_clk_oe, ps2_data_oe);
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_status: ready=%b busy=%b required 1/0", tx_ready, busy);
    end
    checks++;
    if (tx_done !== 1'b0 || tx_ack_err !== 1'b0 || tx_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: %b%b%b required 000", tx_done, tx_ack_err, tx_timeout);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_f4();
    int d0, e0, t0;
    d0 = n_done; e0 = n_err; t0 = n_to;
    run_frame(8'hF4, 11, 1'b0, 1'b0, 1'b0);
    check_result("send_f4", n_done - d0, n_err - e0, n_to - t0, 1, 0, 0);
  endtask

  task automatic test_ack_err();
    int d0, e0, t0;
    d0 = n_done; e0 = n_err; t0 = n_to;
    run_frame(8'hFF, 11, 1'b1, 1'b0, 1'b0);
    check_result("ack_err", n_done - d0, n_err - e0, n_to - t0, 0, 1, 0);
  endtask

  task automatic test_shift_timeout();
    int d0, e0, t0, k;
    d0 = n_done; e0 = n_err; t0 = n_to;
    run_frame(8'h00, 4, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (tx_timeout !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    // 40 cycles elapsed inside run_frame since the last clock-low; the window
    // absorbs the two-flop synchroniser and edge-detect latency
    checks++;
    if (tx_timeout !== 1'b1 || (40 + k) < 200 || (40 + k) > 204) begin
      errors++; $display("FAIL shift_timeout_time: cycles=%0d required 200..204", 40 + k);
    end
    @(negedge clk);
    check_result("shift_timeout", n_done - d0, n_err - e0, n_to - t0, 0, 0, 1);
  endtask

  task automatic test_ignore_busy();
    int d0, e0, t0;
    d0 = n_done; e0 = n_err; t0 = n_to;
    run_frame(8'h12, 11, 1'b0, 1'b0, 1'b1);
    check_result("ignore_inflight", n_done - d0, n_err - e0, n_to - t0, 1, 0, 0);
    d0 = n_done;
    run_frame(8'hAA, 11, 1'b0, 1'b0, 1'b0);
    check_result("send_aa", n_done - d0, n_err - e0, n_to - t0, 1, 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0, t0;
    run_frame(8'h00, 3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ps2_data_oe !== 1'b1) begin
      errors++; $display("FAIL mid_shift_data: data_oe=%b required 1", ps2_data_oe);
    end
    d0 = n_done; e0 = n_err; t0 = n_to;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL async_release: clk_oe=%b data_oe=%b required 0/0", ps2_clk_oe, ps2_data_oe);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check_result("reset_no_pulse", n_done - d0, n_err - e0, n_to - t0, 0, 0, 0);
    d0 = n_done;
    run_frame(8'hF4, 11, 1'b0, 1'b0, 1'b0);
    check_result("after_reset", n_done - d0, n_err - e0, n_to - t0, 1, 0, 0);
  endtask

  task automatic test_wait_idle_timeout();
    int d0, e0, t0, k;
    d0 = n_done; e0 = n_err; t0 = n_to;
    run_frame(8'h55, 11, 1'b0, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL wait_idle_hold: busy=%b required 1", busy);
    end
    k = 0;
    while (tx_timeout !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check_result("wait_idle_timeout", n_done - d0, n_err - e0, n_to - t0, 0, 0, 1);
    dev_data_low = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (n_multi != 0) begin
      errors++; $display("FAIL pulse_exclusive: overlaps=%0d required 0", n_multi);
    end
    checks++;
    if (n_bad_ready != 0) begin
      errors++; $display("FAIL pulse_with_ready: bad=%0d required 0", n_bad_ready);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    test_reset();
    test_send_f4();
    test_ack_err();
    test_shift_timeout();
    test_ignore_busy();
    test_reset_mid_frame();
    test_wait_idle_timeout();
    test_pulse_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
